// File: rtl/hyperbus_arbiter_if.sv
// hyperbus_arbiter_if: requester and controller signals of the two-port HyperBus arbiter
// Parameters: LEN_W burst length width, DW word width.
// Signals: p0_*/p1_* requester ports (req/we/reg/adr/len/wdat in, gnt/wready/rdat/rvalid/done/err out),
// hb_* controller side (adr/dat_w/reg_space/wrq/rrq out, dat_r/ready/valid/busy/error in).
// Modports: slave = arbiter view, master = requesters plus controller view.
interface hyperbus_arbiter_if #(
  parameter int LEN_W = 6,
  parameter int DW = 16
);
  logic p0_req, p0_we, p0_reg;
  logic [31:0] p0_adr;
  logic [LEN_W-1:0] p0_len;
  logic [DW-1:0] p0_wdat, p0_rdat;
  logic p0_gnt, p0_wready, p0_rvalid, p0_done, p0_err;
  logic p1_req, p1_we, p1_reg;
  logic [31:0] p1_adr;
  logic [LEN_W-1:0] p1_len;
  logic [DW-1:0] p1_wdat, p1_rdat;
  logic p1_gnt, p1_wready, p1_rvalid, p1_done, p1_err;
  logic [31:0] hb_adr;
  logic [DW-1:0] hb_dat_w, hb_dat_r;
  logic hb_reg_space, hb_wrq, hb_rrq, hb_ready, hb_valid, hb_busy, hb_error;
  modport slave (
    input p0_req, p0_we, p0_reg, p0_adr, p0_len, p0_wdat,
    input p1_req, p1_we, p1_reg, p1_adr, p1_len, p1_wdat,
    input hb_dat_r, hb_ready, hb_valid, hb_busy, hb_error,
    output p0_gnt, p0_wready, p0_rdat, p0_rvalid, p0_done, p0_err,
    output p1_gnt, p1_wready, p1_rdat, p1_rvalid, p1_done, p1_err,
    output hb_adr, hb_dat_w, hb_reg_space, hb_wrq, hb_rrq
  );
  modport master (
    output p0_req, p0_we, p0_reg, p0_adr, p0_len, p0_wdat,
    output p1_req, p1_we, p1_reg, p1_adr, p1_len, p1_wdat,
    output hb_dat_r, hb_ready, hb_valid, hb_busy, hb_error,
    input p0_gnt, p0_wready, p0_rdat, p0_rvalid, p0_done, p0_err,
    input p1_gnt, p1_wready, p1_rdat, p1_rvalid, p1_done, p1_err,
    input hb_adr, hb_dat_w, hb_reg_space, hb_wrq, hb_rrq
  );
endinterface

// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: two-port round-robin arbiter and burst sequencer in front of the HyperBus controller
// Ports: clk90 block clock; rst asynchronous active-high reset;
// bus (hyperbus_arbiter_if.slave) carries both requester ports and the controller interface.
// Parameters: LEN_W burst length width, DW word width, TIMEOUT watchdog limit in strobe-free cycles.
// Build option: define HBUS_ARB_WATCHDOG_EN to abort bursts that see no word strobe for TIMEOUT cycles.
module hyperbus_arbiter #(
  parameter int LEN_W = 6,
  parameter int DW = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk90,
  input logic rst,
  hyperbus_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  logic [1:0] state;
  logic port, last, we_l, reg_l, done_r, err_r;
  logic [31:0] adr_l;
  logic [LEN_W-1:0] len_l, cnt, req_len;
  logic [DW-1:0] wdat;
  logic xfer, owned, strobe, last_word, abort, grant, pick;
  assign xfer = (state == XFER);
  assign owned = (state != IDLE);
  assign strobe = xfer & (we_l ? bus.hb_ready : bus.hb_valid);
  // the length was latched at grant, so the count can never run past it
  assign last_word = strobe & (LEN_W'(cnt + 1'b1) == len_l);
  assign grant = (state == IDLE) & ~bus.hb_busy & (bus.p0_req | bus.p1_req);
  // contested grant goes to the port that did not own the bus last
  assign pick = (bus.p0_req & bus.p1_req) ? ~last : bus.p1_req;
  assign req_len = pick ? bus.p1_len : bus.p0_len;
  assign wdat = port ? bus.p1_wdat : bus.p0_wdat;
`ifdef HBUS_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd;
  // wd counts strobe-free XFER cycles; it is zero on the first XFER cycle
  always_ff @(posedge clk90 or posedge rst)
    if (rst) wd <= '0;
    else wd <= (!xfer || strobe) ? '0 : wd + 1'b1;
  assign abort = xfer & (bus.hb_error | (~strobe & (wd == WD_W'(TIMEOUT - 1))));
`else
  assign abort = xfer & bus.hb_error;
`endif
  always_ff @(posedge clk90 or posedge rst)
    if (rst) begin
      state <= IDLE;
      port <= 1'b0;
      last <= 1'b1;
      we_l <= 1'b0;
      reg_l <= 1'b0;
      adr_l <= '0;
      len_l <= '0;
      cnt <= '0;
      done_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      done_r <= abort | last_word;
      err_r <= abort;
      if (grant) begin
        state <= XFER;
        port <= pick;
        we_l <= pick ? bus.p1_we : bus.p0_we;
        reg_l <= pick ? bus.p1_reg : bus.p0_reg;
        adr_l <= pick ? bus.p1_adr : bus.p0_adr;
        len_l <= (req_len == '0) ? LEN_W'(1) : req_len;
        cnt <= '0;
      end else if (xfer) begin
        if (abort | last_word) state <= DRAIN;
        if (strobe) cnt <= cnt + 1'b1;
      end else if (state == DRAIN && !done_r && !bus.hb_busy) begin
        // skipping the done cycle gives the controller a cycle to raise hb_busy
        state <= IDLE;
        last <= port;
      end
    end
  assign bus.hb_wrq = xfer & we_l;
  assign bus.hb_rrq = xfer & ~we_l;
  assign bus.hb_adr = xfer ? adr_l : '0;
  assign bus.hb_reg_space = xfer & reg_l;
  assign bus.hb_dat_w = (xfer & we_l) ? wdat : '0;
  assign bus.p0_gnt = owned & ~port;
  assign bus.p1_gnt = owned & port;
  assign bus.p0_wready = strobe & we_l & ~port;
  assign bus.p1_wready = strobe & we_l & port;
  assign bus.p0_rvalid = strobe & ~we_l & ~port;
  assign bus.p1_rvalid = strobe & ~we_l & port;
  assign bus.p0_rdat = bus.p0_rvalid ? bus.hb_dat_r : '0;
  assign bus.p1_rdat = bus.p1_rvalid ? bus.hb_dat_r : '0;
  assign bus.p0_done = done_r & ~port;
  assign bus.p1_done = done_r & port;
  assign bus.p0_err = err_r & ~port;
  assign bus.p1_err = err_r & port;
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb_hyperbus_arbiter: self-checking bench for hyperbus_arbiter (table, directed and random bursts)
module tb_hyperbus_arbiter;
  localparam int LEN_W = 6, DW = 16, TIMEOUT = 20;
  logic clk90 = 1'b0;
  logic rst = 1'b1;
  always #5 clk90 = ~clk90;
  hyperbus_arbiter_if #(.LEN_W(LEN_W), .DW(DW)) bus ();
  hyperbus_arbiter #(.LEN_W(LEN_W), .DW(DW), .TIMEOUT(TIMEOUT)) dut (.clk90(clk90), .rst(rst), .bus(bus));
  int n_cmp = 0, n_bad = 0, last = 1;
  logic [DW-1:0] rdq[$];
  typedef struct {bit r0; bit r1; int busy; bit we; logic [LEN_W-1:0] len; int exp_w;} vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic gnt(input int p); return p != 0 ? bus.p1_gnt : bus.p0_gnt; endfunction
  function automatic logic wready(input int p); return p != 0 ? bus.p1_wready : bus.p0_wready; endfunction
  function automatic logic rvalid(input int p); return p != 0 ? bus.p1_rvalid : bus.p0_rvalid; endfunction
  function automatic logic done(input int p); return p != 0 ? bus.p1_done : bus.p0_done; endfunction
  function automatic logic err(input int p); return p != 0 ? bus.p1_err : bus.p0_err; endfunction
  function automatic logic [DW-1:0] rdat(input int p); return p != 0 ? bus.p1_rdat : bus.p0_rdat; endfunction

  task automatic tick; @(posedge clk90); #1; endtask
  task automatic samp; @(negedge clk90); endtask

  task automatic set_req(input int p, input bit r, input bit we, input bit rg, input logic [31:0] a,
                         input logic [LEN_W-1:0] l);
    if (p != 0) begin
      bus.p1_req = r; bus.p1_we = we; bus.p1_reg = rg; bus.p1_adr = a; bus.p1_len = l;
    end else begin
      bus.p0_req = r; bus.p0_we = we; bus.p0_reg = rg; bus.p0_adr = a; bus.p0_len = l;
    end
  endtask

  task automatic set_wdat(input int p, input logic [DW-1:0] d);
    if (p != 0) bus.p1_wdat = d;
    else bus.p0_wdat = d;
  endtask

  // called in the IDLE cycle where the requests were just raised; returns right after the grant edge
  task automatic arb(input int busy_n);
    bus.hb_busy = busy_n > 0;
    samp;
    chk("idle_no_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
    for (int i = 0; i < busy_n; i++) begin
      tick;
      if (i == busy_n - 1) bus.hb_busy = 1'b0;
      samp;
      chk("busy_no_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
    end
    tick;
  endtask

  // drives the controller through one granted burst and checks every XFER cycle plus the done cycle
  task automatic xfer_burst(input int p, input bit we, input bit rg, input logic [31:0] a,
                            input int need, input int pct, input int err_at);
    int got;
    bit s, ab;
    logic [DW-1:0] d, wd;
    got = 0;
    ab = 1'b0;
    for (int cyc = 0; cyc < 1000 && got < need && !ab; cyc++) begin
      ab = (got == err_at);
      s = !ab && ($urandom_range(0, 99) < pct);
      d = DW'($urandom);
      if (s && !we && rdq.size() > 0) d = rdq.pop_front();
      wd = DW'($urandom);
      set_wdat(p, wd);
      bus.hb_ready = s & we; bus.hb_valid = s & ~we; bus.hb_dat_r = d; bus.hb_error = ab;
      samp;
      chk("gnt", gnt(p), 1);
      chk("gnt_other", gnt(1 - p), 0);
      chk("wrq", bus.hb_wrq, we);
      chk("rrq", bus.hb_rrq, !we);
      chk("hb_adr", bus.hb_adr, a);
      chk("reg_space", bus.hb_reg_space, rg);
      chk("wready", wready(p), s & we);
      chk("rvalid", rvalid(p), s & !we);
      chk("other_strobes", {wready(1 - p), rvalid(1 - p)}, 0);
      chk("early_done", done(p), 0);
      if (we) chk("hb_dat_w", bus.hb_dat_w, wd);
      if (s && !we) chk("rdat", rdat(p), d);
      if (s) got++;
      tick;
      bus.hb_ready = 1'b0; bus.hb_valid = 1'b0; bus.hb_error = 1'b0;
    end
    if (!ab) chk("burst_words", got, need);
    samp;
    chk("done", done(p), 1);
    chk("err", err(p), ab);
    chk("done_other", {done(1 - p), err(1 - p)}, 0);
    chk("rq_dropped", {bus.hb_wrq, bus.hb_rrq}, 0);
  endtask

  // after the done cycle: hold busy for busy_n cycles, then the grant must be released
  task automatic drain(input int p, input int busy_n);
    tick;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    bus.hb_busy = busy_n > 0;
    samp;
    chk("done_one_cycle", done(p), 0);
    chk("drain_gnt", gnt(p), 1);
    for (int i = 0; i < busy_n; i++) begin
      tick;
      if (i == busy_n - 1) bus.hb_busy = 1'b0;
      samp;
      chk("drain_busy_gnt", gnt(p), 1);
    end
    tick;
    samp;
    chk("released", {bus.p0_gnt, bus.p1_gnt}, 0);
    last = p;
  endtask

  task automatic do_reset;
    tick;
    rst = 1'b1;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.hb_busy = 1'b0;
    bus.hb_ready = 1'b0; bus.hb_valid = 1'b0; bus.hb_error = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    last = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_at;
    vecs[0] = '{1'b1, 1'b1, 0, 1'b1, 6'd2, 0};
    vecs[1] = '{1'b1, 1'b1, 2, 1'b0, 6'd1, 1};
    vecs[2] = '{1'b1, 1'b1, 1, 1'b1, 6'd3, 0};
    vecs[3] = '{1'b1, 1'b1, 0, 1'b0, 6'd2, 1};
    vecs[4] = '{1'b0, 1'b1, 0, 1'b1, 6'd1, 1};
    vecs[5] = '{1'b0, 1'b1, 1, 1'b0, 6'd0, 1};
    vecs[6] = '{1'b1, 1'b1, 0, 1'b1, 6'd1, 0};
    vecs[7] = '{1'b1, 1'b0, 0, 1'b0, 6'd2, 0};
    vecs[8] = '{1'b1, 1'b1, 0, 1'b1, 6'd1, 1};
    vecs[9] = '{1'b1, 1'b0, 0, 1'b1, 6'd0, 0};
    set_req(0, 1'b0, 1'b1, 1'b1, '1, '1);
    set_req(1, 1'b0, 1'b1, 1'b1, '1, '1);
    bus.p0_wdat = '1; bus.p1_wdat = '1; bus.hb_dat_r = '1;
    bus.hb_ready = 1'b1; bus.hb_valid = 1'b1; bus.hb_busy = 1'b0; bus.hb_error = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    samp;
    chk("rst_hb_adr", bus.hb_adr, 0);
    chk("rst_hb_dat_w", bus.hb_dat_w, 0);
    chk("rst_hb_ctl", {bus.hb_wrq, bus.hb_rrq, bus.hb_reg_space}, 0);
    chk("rst_p0", {bus.p0_gnt, bus.p0_wready, bus.p0_rvalid, bus.p0_done, bus.p0_err}, 0);
    chk("rst_p1", {bus.p1_gnt, bus.p1_wready, bus.p1_rvalid, bus.p1_done, bus.p1_err}, 0);
    chk("rst_rdat", {bus.p0_rdat, bus.p1_rdat}, 0);
    tick;
    rst = 1'b0;
    bus.hb_ready = 1'b0; bus.hb_valid = 1'b0;
    // port 0 write, 4 back-to-back words
    tick;
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h100, 6'd4);
    arb(0);
    xfer_burst(0, 1'b1, 1'b0, 32'h100, 4, 100, -1);
    drain(0, 1);
    // port 1 read of three known words with gaps
    rdq = '{16'hA1A1, 16'hB2B2, 16'hC3C3};
    tick;
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h2000, 6'd3);
    arb(0);
    xfer_burst(1, 1'b0, 1'b0, 32'h2000, 3, 40, -1);
    chk("rdq_consumed", rdq.size(), 0);
    drain(1, 0);
    // length 0 is a single word
    tick;
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h55, 6'd0);
    arb(0);
    xfer_burst(0, 1'b0, 1'b1, 32'h55, 1, 100, -1);
    drain(0, 0);
    // arbitration table from a fresh pointer
    do_reset;
    foreach (vecs[i]) begin
      tick;
      set_req(0, vecs[i].r0, vecs[i].we, 1'b0, 32'h1000 + i, vecs[i].len);
      set_req(1, vecs[i].r1, vecs[i].we, 1'b1, 32'h8000 + i, vecs[i].len);
      arb(vecs[i].busy);
      xfer_burst(vecs[i].exp_w, vecs[i].we, vecs[i].exp_w == 1,
                 vecs[i].exp_w == 1 ? 32'h8000 + i : 32'h1000 + i,
                 vecs[i].len == 0 ? 1 : int'(vecs[i].len), 100, -1);
      drain(vecs[i].exp_w, 0);
    end
    // random bursts against a transaction-level model of the round-robin rule
    for (int k = 0; k < 40; k++) begin
      bit r0, r1, we0, we1;
      logic [31:0] a0, a1;
      logic [LEN_W-1:0] l0, l1;
      int w, need;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      a0 = $urandom; a1 = $urandom;
      l0 = LEN_W'($urandom_range(0, 9)); l1 = LEN_W'($urandom_range(0, 9));
      w = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
      need = (w == 1) ? int'(l1) : int'(l0);
      if (need == 0) need = 1;
      tick;
      set_req(0, r0, we0, 1'b0, a0, l0);
      set_req(1, r1, we1, 1'b1, a1, l1);
      arb($urandom_range(0, 2));
      xfer_burst(w, w == 1 ? we1 : we0, w == 1, w == 1 ? a1 : a0, need, $urandom_range(30, 100), -1);
      drain(w, $urandom_range(0, 2));
    end
    // no strobes at all: watchdog abort or indefinite wait
    do_reset;
    tick;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h700, 6'd4);
    arb(0);
    done_at = 0;
    for (int c = 1; c <= 1000; c++) begin
      samp;
      if (bus.p0_done) begin
        done_at = c;
        break;
      end
      tick;
    end
`ifdef HBUS_ARB_WATCHDOG_EN
    chk("wd_done_cycle", done_at, 21);
    chk("wd_err", bus.p0_err, 1);
`else
    chk("no_wd_abort", done_at, 0);
    chk("still_rrq", bus.hb_rrq, 1);
`endif
    // controller error after 2 of 8 words: arbiter stays parked until reset
    do_reset;
    tick;
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h300, 6'd8);
    arb(0);
    xfer_burst(0, 1'b1, 1'b0, 32'h300, 8, 100, 2);
    tick;
    bus.hb_busy = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h310, 6'd2);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h400, 6'd2);
    for (int i = 0; i < 10; i++) begin
      samp;
      chk("stuck_no_gnt1", bus.p1_gnt, 0);
      chk("stuck_rq", {bus.hb_wrq, bus.hb_rrq}, 0);
      chk("stuck_done", {bus.p0_done, bus.p1_done}, 0);
      tick;
    end
    #2 rst = 1'b1;
    #1 chk("async_rst_gnt", bus.p0_gnt, 0);
    do_reset;
    // asynchronous reset in the middle of a burst
    tick;
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h900, 6'd5);
    arb(0);
    samp;
    chk("mid_wrq_before", bus.hb_wrq, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wrq", bus.hb_wrq, 0);
    chk("mid_rst_adr", bus.hb_adr, 0);
    chk("mid_rst_gnt", bus.p1_gnt, 0);
    do_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Two-port round-robin arbiter and burst sequencer in front of the HyperBus primary controller. It accepts read and write burst requests from two independent requesters and grants one at a time. It drives the controller's address, write data, register-space select and the hold-high `wrq`/`rrq` request. It counts transferred 16-bit words and drops the request after the programmed burst length, which frees the shared HyperRAM for the other requester.

## Interface
- `LEN_W`, 6: width of burst length fields; maximum burst is 2^LEN_W-1 words.
- `DW`, 16: word width; equals the controller's double-width data bus.
- `TIMEOUT`, 255: watchdog limit, in cycles without a word strobe (see Configuration).
- `clk90`  in  1  block clock.
- `rst`  in  1  asynchronous reset, active-high.
- `pN_req`  in  1  burst request from port N (N=0,1); held until `pN_done`.
- `pN_we`  in  1  1=write, 0=read; stable while `pN_req`.
- `pN_reg`  in  1  register-space access; stable while `pN_req`.
- `pN_adr`  in  32  start word address; stable while `pN_req`.
- `pN_len`  in  LEN_W  burst length in words; 0 is treated as 1.
- `pN_wdat`  in  DW  write word, consumed on `pN_wready`.
- `pN_gnt`  out  1  port N owns the controller.
- `pN_wready`  out  1  current `pN_wdat` accepted this cycle.
- `pN_rdat`  out  DW  read word.
- `pN_rvalid`  out  1  `pN_rdat` valid, one-cycle strobe.
- `pN_done`  out  1  one-cycle pulse when the burst ends, normally or aborted.
- `pN_err`  out  1  qualifies `pN_done`: burst aborted.
- `hb_adr`  out  32  controller address.
- `hb_dat_w`  out  DW  controller write data.
- `hb_reg_space`  out  1  controller register-space select.
- `hb_wrq`  out  1  controller write request.
- `hb_rrq`  out  1  controller read request.
- `hb_dat_r`  in  DW  controller read data.
- `hb_ready`, `hb_valid`, `hb_busy`, `hb_error`  in  1 each  controller status.

## Operation
- States: IDLE, XFER, DRAIN.
- IDLE: the arbiter grants only when `hb_busy`=0 and at least one `pN_req`=1.
  - Single requester: that port is granted.
  - Both requesting: the port not granted last wins. The last-grant pointer resets to port 1, so port 0 wins the first contest.
  - On grant: latch port index, `we`, `reg`, `adr` and length (len 0 → 1); clear the word counter; go to XFER.
- XFER: the granted port's `pN_adr`, `pN_reg` and `pN_wdat` are muxed onto `hb_*`. `hb_wrq`=we and `hb_rrq`=!we, held high.
  - Write word strobe = `hb_ready`. `pN_wready` = `hb_ready` for the granted port.
  - Read word strobe = `hb_valid`. `pN_rdat`=`hb_dat_r`; `pN_rvalid` = `hb_valid` for the granted port.
  - Each strobe increments the counter. The strobe that brings the count to len is the last word: the next cycle drops `hb_wrq`/`hb_rrq`, pulses `pN_done`, and enters DRAIN.
- DRAIN: stay until `hb_busy`=0, then go to IDLE, drop `pN_gnt` and update the pointer.
- Abort: `hb_error`=1 in XFER drops the request, pulses `pN_done` with `pN_err`=1, and enters DRAIN. While in error, the controller holds `hb_busy`; the arbiter stays in DRAIN until `rst`.
- The ungranted port sees `pN_gnt`, `pN_wready`, `pN_rvalid` and `pN_done` all at 0.
- Dropping `pN_req` mid-burst is ignored; the burst completes.

## Timing
- Reset: state IDLE. All outputs are 0, including `hb_adr`, `hb_dat_w` and all `pN_rdat`. Pointer resets to port 1 and the counter to 0.
- Reset mid-burst drops `hb_wrq`/`hb_rrq` immediately (asynchronous).
- Grant latency: `pN_req` sampled high in IDLE → `pN_gnt`, `hb_*rq` and the muxed `hb_adr` all high the next cycle.
- `pN_wready`/`pN_rvalid` are combinational from `hb_ready`/`hb_valid`, with zero added latency.
- Last-word strobe at cycle t → `hb_*rq`=0 and `pN_done`=1 at t+1.
- Minimum gap between bursts: done cycle + ≥1 DRAIN cycle + the IDLE sample cycle.
- Counter width is LEN_W. The count compare uses the latched length, so it cannot wrap.

## Configuration
- `HBUS_ARB_WATCHDOG_EN` defined: an 8-bit-or-wider idle counter runs in XFER.
  - It is cleared on every word strobe and on entry to XFER.
  - Reaching TIMEOUT aborts the burst exactly as `hb_error` does: `pN_done`+`pN_err`, then DRAIN.
- Not defined: no watchdog logic is built; XFER waits indefinitely for strobes.

## Test plan
- Port 0 write, adr 0x100, len 4, `hb_ready` high 4 cycles → four `p0_wready` strobes; `hb_wrq` drops the cycle after the 4th; `p0_done`=1, `p0_err`=0.
- Port 1 read, len 3, `hb_valid` pulses with data 0xA1A1, 0xB2B2, 0xC3C3 spaced by gaps → `p1_rvalid` ×3 with matching `p1_rdat`, then `p1_done`.
- Both ports request at once, repeated 4 times → grants alternate 0,1,0,1; no grant while `hb_busy`=1.
- Port 0 read, len 0 → exactly one word transferred, then done.
- `hb_error` asserted after 2 of 8 words → request drops the next cycle, `p0_done`=`p0_err`=1, and no further grants until `rst`.
- With `HBUS_ARB_WATCHDOG_EN` and TIMEOUT=20, no strobes → abort with `pN_err`=1 at cycle 21 of XFER; without the macro, no abort after 1000 cycles.
